// File: rtl/sqrt_arb_pkg.sv
// Shared types and default sizing for the square-root arbiter.
package sqrt_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_WIDTH        = 12;
    localparam int DEF_SQRT_LATENCY = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after i_last_grant, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last_grant,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_pos;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = |i_req;
        w_pos   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            w_pos = IW'((int'(i_last_grant) + k) % N);
            if (!w_found && i_req[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin front end sharing one fixed-latency SquareRoot core among NUM_REQ requesters.
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter  int NUM_REQ      = DEF_NUM_REQ,
    parameter  int WIDTH        = DEF_WIDTH,
    parameter  int SQRT_LATENCY = DEF_SQRT_LATENCY,
    localparam int IW           = $clog2(NUM_REQ),
    localparam int CW           = (SQRT_LATENCY > 1) ? $clog2(SQRT_LATENCY) : 1
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_operand,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     sqrt_start,
    output logic [WIDTH-1:0]         sqrt_a,
    input  logic [WIDTH-1:0]         sqrt_q,
    output logic                     busy,
    output logic [IW-1:0]            grant_id
);

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_result;
    logic [IW-1:0]     r_grant;
    logic [IW-1:0]     r_last;
    logic [CW-1:0]     r_cnt;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]     w_idx;
    logic              w_any;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req        (req_valid),
        .i_last_grant (r_last),
        .o_grant      (w_gnt),
        .o_idx        (w_idx),
        .o_any        (w_any)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        rsp_valid  = '0;
        sqrt_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    req_ready = w_gnt;
                    w_next    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                sqrt_start = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == '0) w_next = S_RESPOND;
            end
            S_RESPOND: begin
                rsp_valid[r_grant] = 1'b1;
                if (rsp_ready[r_grant]) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The core has no done flag, so its result is captured purely by cycle count.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_a      <= '0;
            r_result <= '0;
            r_grant  <= '0;
            r_last   <= IW'(NUM_REQ - 1);
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a     <= req_operand[w_idx*WIDTH +: WIDTH];
                        r_grant <= w_idx;
                    end
                end
                S_ISSUE: r_cnt <= CW'(SQRT_LATENCY - 1);
                S_WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) r_result <= sqrt_q;
                end
                S_RESPOND: begin
                    if (rsp_ready[r_grant]) r_last <= r_grant;
                end
                default: ;
            endcase
        end
    end

    assign sqrt_a     = r_a;
    assign rsp_result = r_result;
    assign grant_id   = r_grant;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
Shares one fixed-latency square-root core (SquareRoot) between NUM_REQ requesters.
- Accepts operands over per-requester valid/ready handshakes and arbitrates round-robin.
- Drives the core's start/A inputs and counts the core latency, since the core has no done flag.
- Returns each result over a per-requester valid/ready response channel.
- Sits between the geometry/normalisation units and the single SquareRoot instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
WIDTH, 12, operand/result width; matches SquareRoot A/Q.
SQRT_LATENCY, 8, cycles from the edge sampling sqrt_start=1 to sqrt_q valid; must be >= 1.

Ports:
clk  in  1  system clock, rising edge.
rst_  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  per-requester operand valid.
req_ready  out  NUM_REQ  one-hot operand accept.
req_operand  in  NUM_REQ*WIDTH  flattened operands; requester i at [i*WIDTH +: WIDTH].
rsp_valid  out  NUM_REQ  one-hot result valid.
rsp_ready  in  NUM_REQ  per-requester result accept.
rsp_result  out  WIDTH  shared result bus; meaningful only while any rsp_valid is high.
sqrt_start  out  1  one-cycle start pulse to the core.
sqrt_a  out  WIDTH  core operand.
sqrt_q  in  WIDTH  core result.
busy  out  1  high whenever the state is not IDLE.
grant_id  out  $clog2(NUM_REQ)  index of the requester currently owning the core.

Behaviour:
- Reset (async, rst_=0): state=IDLE. req_ready, rsp_valid, sqrt_start, sqrt_a, rsp_result, busy and grant_id are all 0. last_grant=NUM_REQ-1, so requester 0 has top priority first.
- Reset mid-operation aborts the transaction silently: no response is issued and the core result is ignored.
- State IDLE:
  - If no req_valid, remain in IDLE.
  - Otherwise the winner is the first set req_valid bit searching from last_grant+1 upward, wrapping.
  - req_ready[winner]=1 combinationally in that same cycle; that is the accept cycle T.
  - At the edge: latch the operand into a_reg, latch grant_id=winner, go to ISSUE.
  - req_ready is 0 in every other state.
- State ISSUE (cycle T+1):
  - sqrt_start=1 and sqrt_a=a_reg.
  - Load cnt=SQRT_LATENCY-1, go to WAIT.
- State WAIT:
  - sqrt_start=0; sqrt_a held at a_reg.
  - Decrement cnt each cycle.
  - When cnt==0 (cycle T+1+SQRT_LATENCY), capture sqrt_q into result_reg and go to RESPOND.
- State RESPOND (from cycle T+2+SQRT_LATENCY):
  - rsp_valid[grant_id]=1 and rsp_result=result_reg, both held stable until rsp_ready[grant_id]=1.
  - On that handshake: last_grant=grant_id, go to IDLE.
  - rsp_ready of other requesters is ignored.
- Accept-to-response latency is SQRT_LATENCY+2 cycles. Minimum issue interval is SQRT_LATENCY+3 cycles, since no new accept happens in the cycle of the response handshake.
- Operands are sampled only in the accept cycle. Later changes to req_operand and deassertion of req_valid after accept have no effect.
- A requester may drop req_valid before being granted; it is simply skipped.
- A requester whose response is pending may assert req_valid again; it is arbitrated normally after returning to IDLE.
- sqrt_a and rsp_result keep their last values when idle (not cleared).
- The result is passed through unmodified; width and format are those of the core.

Decomposition:
- Package sqrt_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESPOND) and default WIDTH/SQRT_LATENCY constants.
- Sub-module rr_arbiter: combinational round-robin pick, inputs req vector and last_grant, outputs one-hot grant, index and any_req.
- The SquareRoot core is instantiated outside this block, at the same level.

Test Plan:
(Bench uses a behavioural core: floor(sqrt(A)) presented SQRT_LATENCY cycles after start; SQRT_LATENCY=8.)
1. Single request: req_valid[0]=1, operand 256, one cycle after reset → req_ready[0] in cycle 0; sqrt_start pulse with sqrt_a=256 in cycle 1; rsp_valid[0] from cycle 10 with rsp_result=16; IDLE after rsp_ready.
2. Contention: all four valid together with operands 4, 9, 16, 25, rsp_ready tied 1 → served in order 0, 1, 2, 3. Results 2, 3, 4, 5 appear on matching rsp_valid bits, with accepts 11 cycles apart.
3. Fairness: req_valid[0] and req_valid[2] held high continuously → grant_id sequence 0, 2, 0, 2; requesters 1 and 3 never acked.
4. Backpressure: request from 1 (operand 100), rsp_ready[1] low 5 cycles during RESPOND → rsp_valid[1]=1, rsp_result=10 and busy=1 stable, with no req_ready. Releasing rsp_ready → IDLE next cycle.
5. Reset mid-WAIT: assert rst_=0 three cycles after sqrt_start → all outputs 0 immediately and no rsp_valid. After release, with req 0 and req 3 valid, requester 0 wins.
6. Operand change: after accept of operand 49, change req_operand to 400 during WAIT → sqrt_a stays 49 and rsp_result=7.
